// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream (MSB first) into 16-bit words and writes them to
// sequential addresses. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_HI, S_LOAD_LO, S_WRITE, S_DONE, S_CHK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_HI, S_LOAD_LO, S_WRITE, S_DONE
    } state_t;
`endif

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [LEN_W-1:0]  idx_reg, idx_next;
    logic [LEN_W-1:0]  idx_inc;
    logic [15:0]       word_reg, word_next;
    logic              err_reg, err_next;
    logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_reg, xor_next;
`endif

    assign idx_inc = idx_reg + 1'b1;
    assign accept  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            len_reg   <= '0;
            idx_reg   <= '0;
            word_reg  <= '0;
            err_reg   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
            word_reg  <= word_next;
            err_reg   <= err_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_reg   <= xor_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        word_next  = word_reg;
        err_next   = err_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_next   = xor_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    addr_next  = base_addr;
                    len_next   = length;
                    idx_next   = '0;
                    err_next   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_next   = '0;
`endif
                    state_next = (length == '0) ? S_DONE : S_LOAD_HI;
                end
            end
            S_LOAD_HI: begin
                if (accept) begin
                    word_next[15:8] = in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_next        = xor_reg ^ in_data;
`endif
                    state_next      = S_LOAD_LO;
                end
            end
            S_LOAD_LO: begin
                if (accept) begin
                    word_next[7:0] = in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_next       = xor_reg ^ in_data;
`endif
                    state_next     = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address wraps silently modulo 2^ADDR_W.
                idx_next  = idx_inc;
                addr_next = addr_reg + 1'b1;
                if (idx_inc == len_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = S_CHK;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_LOAD_HI;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (in_data != xor_reg) err_next = 1'b1;
                    state_next = S_DONE;
                end
            end
`endif
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Abort overrides everything outside IDLE; a partially packed word is simply dropped.
        if (abort && state_reg != S_IDLE) begin
            state_next = S_IDLE;
            err_next   = 1'b1;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_ready = (state_reg == S_LOAD_HI) || (state_reg == S_LOAD_LO) || (state_reg == S_CHK);
`else
    assign in_ready = (state_reg == S_LOAD_HI) || (state_reg == S_LOAD_LO);
`endif
    assign mem_we    = (state_reg == S_WRITE);
    assign mem_addr  = addr_reg;
    assign mem_wdata = word_reg;
    assign busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done      = (state_reg == S_DONE) && !abort;
    assign err       = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued as stimulus is driven and
// matched against each mem_we strobe; done/err/busy are checked per scenario.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] length;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_count = 0;
    int exp_done   = 0;
    logic [47:0] exp_q[$];

    imem_loader #(.ADDR_W(32), .LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && done) done_count <= done_count + 1;
        if (rst_n && mem_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             mem_addr, mem_wdata, e[47:16], e[15:0]);
                end else begin
                    $display("write ok addr=%h data=%h", mem_addr, mem_wdata);
                end
            end
        end
    end

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic ok;
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = b; ok = 1'b0; n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL byte_accept: in_ready=%b after %0d cycles, required 1", ok, n);
        end
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        exp_done++;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done: done=0 after timeout, required 1", tag);
        end
        @(posedge clk); #1;
        n_checks++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s_err: got %b, required %b", tag, err, exp_err);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b done=%b, required 0 0", tag, busy, done);
        end
        n_checks++;
        if (done_count !== exp_done) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d, required %0d", tag, done_count, exp_done);
        end
        $display("%s load finished err=%b", tag, err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000", {in_ready, mem_we, busy, done, err});
        end
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h data=%h, required 0 0", mem_addr, mem_wdata);
        end
        @(negedge clk); rst_n = 1'b1;
        $display("reset checked");
    endtask

    task automatic test_basic();
        pulse_start(32'h10, 16'd2);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%b in_ready=%b, required 1 1", busy, in_ready);
        end
        exp_q.push_back({32'h10, 16'h1234});
        exp_q.push_back({32'h11, 16'hABCD});
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD, 0);
`endif
        wait_done("basic", 1'b0);
    endtask

    task automatic test_stall();
        pulse_start(32'h10, 16'd2);
        exp_q.push_back({32'h10, 16'h1234});
        exp_q.push_back({32'h11, 16'hABCD});
        send_byte(8'h12, 0); send_byte(8'h34, 2);
        send_byte(8'hAB, 0); send_byte(8'hCD, 2);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD, 1);
`endif
        wait_done("stall", 1'b0);
    endtask

    task automatic test_wrap();
        pulse_start(32'hFFFF_FFFF, 16'd2);
        exp_q.push_back({32'hFFFF_FFFF, 16'hC0DE});
        exp_q.push_back({32'h0000_0000, 16'h0102});
        send_byte(8'hC0, 0); send_byte(8'hDE, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hC0 ^ 8'hDE ^ 8'h01 ^ 8'h02, 0);
`endif
        wait_done("wrap", 1'b0);
    endtask

    task automatic test_zero_length();
        pulse_start(32'h20, 16'd0);
        @(negedge clk);
        exp_done++;
        n_checks++;
        if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: done=%b in_ready=%b busy=%b, required 1 0 0", done, in_ready, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: done=%b in_ready=%b, required 0 0", done, in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done_count !== exp_done) begin
            n_fail++;
            $display("FAIL zero_done_count: got %0d, required %0d", done_count, exp_done);
        end
        $display("zero-length load finished");
    endtask

    task automatic test_abort();
        pulse_start(32'h40, 16'd2);
        exp_q.push_back({32'h40, 16'h5566});
        send_byte(8'h55, 0); send_byte(8'h66, 0);
        pulse_start(32'h99, 16'd5);   // must be ignored while busy
        send_byte(8'h77, 0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: err=%b busy=%b in_ready=%b, required 1 0 0", err, busy, in_ready);
        end
        abort = 1'b1;                 // abort in IDLE is a no-op
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b0;
        n_checks++;
        if (err !== 1'b1 || done_count !== exp_done || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: err=%b done_count=%0d busy=%b, required 1 %0d 0",
                     err, done_count, busy, exp_done);
        end
        // start and abort together in IDLE: start wins
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; base_addr = 32'h80; length = 16'd1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart: err=%b busy=%b, required 0 1", err, busy);
        end
        exp_q.push_back({32'h80, 16'hBEEF});
        send_byte(8'hBE, 0); send_byte(8'hEF, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hBE ^ 8'hEF, 0);
`endif
        wait_done("abort", 1'b0);
    endtask

    task automatic test_reset_mid_load();
        pulse_start(32'h100, 16'd1);
        send_byte(8'hA5, 0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, busy, err, mem_we} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset: in_ready=%b busy=%b err=%b we=%b addr=%h data=%h, required all 0",
                     in_ready, busy, err, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk); rst_n = 1'b1;
        pulse_start(32'h200, 16'd1);
        exp_q.push_back({32'h200, 16'h1357});
        send_byte(8'h13, 0); send_byte(8'h57, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h13 ^ 8'h57, 0);
`endif
        wait_done("midreset", 1'b0);
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start(32'h300, 16'd1);
        exp_q.push_back({32'h300, 16'h1234});
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h26, 0);
        wait_done("chk_good", 1'b0);
        pulse_start(32'h300, 16'd1);
        exp_q.push_back({32'h300, 16'h1234});
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h27, 0);
        wait_done("chk_bad", 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_length();
        test_abort();
        test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_writes: %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
